// File: rtl/mdu_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITERS = 32;

  typedef enum logic {
    MDU_MULT = 1'b0,
    MDU_DIV  = 1'b1
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and
// for sign correction of the product, quotient and remainder.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int W = MDU_WIDTH
) (
  input  logic         neg_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply / restoring divide with start/done handshake.
// Optional build macro MDU_UNSIGNED_EN adds is_unsigned (multu/divu).
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int ITERS = MDU_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
`ifdef MDU_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(ITERS);
  localparam int W2 = 2 * WIDTH;

  mdu_state_t       state_q, state_d;
  mdu_op_t          op_q, op_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             uns_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic             b_zero_s;
  logic [WIDTH:0]   sum_s, rsh_s, diff_s;
  logic [W2-1:0]    mul_next_s, div_next_s, acc_step_s;
  logic [W2-1:0]    prod_fix_s;
  logic [WIDTH-1:0] quot_fix_s, rem_fix_s;
  logic [WIDTH-1:0] res_hi_s, res_lo_s;

`ifdef MDU_UNSIGNED_EN
  assign uns_s = is_unsigned;
`else
  assign uns_s = 1'b0;
`endif

  assign b_zero_s = (b == {WIDTH{1'b0}});

  mdu_sign_fix #(.W(WIDTH)) u_a_mag (
    .neg_i (a[WIDTH-1] & ~uns_s),
    .val_i (a),
    .val_o (a_mag_s)
  );

  mdu_sign_fix #(.W(WIDTH)) u_b_mag (
    .neg_i (b[WIDTH-1] & ~uns_s),
    .val_i (b),
    .val_o (b_mag_s)
  );

  // Shift-add step: acc = {partial product, remaining multiplier bits}.
  assign sum_s      = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});
  assign mul_next_s = {sum_s, acc_q[WIDTH-1:1]};

  // Restoring step: acc = {partial remainder, dividend/quotient bits}; borrow means restore.
  assign rsh_s      = acc_q[W2-1:WIDTH-1];
  assign diff_s     = rsh_s - {1'b0, dvs_q};
  assign div_next_s = diff_s[WIDTH] ? {rsh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign acc_step_s = (op_q == MDU_DIV) ? div_next_s : mul_next_s;

  mdu_sign_fix #(.W(W2)) u_prod_fix (
    .neg_i (neg_q),
    .val_i (acc_step_s),
    .val_o (prod_fix_s)
  );

  mdu_sign_fix #(.W(WIDTH)) u_quot_fix (
    .neg_i (neg_q),
    .val_i (acc_step_s[WIDTH-1:0]),
    .val_o (quot_fix_s)
  );

  mdu_sign_fix #(.W(WIDTH)) u_rem_fix (
    .neg_i (rneg_q),
    .val_i (acc_step_s[W2-1:WIDTH]),
    .val_o (rem_fix_s)
  );

  assign res_hi_s = (op_q == MDU_DIV) ? rem_fix_s  : prod_fix_s[W2-1:WIDTH];
  assign res_lo_s = (op_q == MDU_DIV) ? quot_fix_s : prod_fix_s[WIDTH-1:0];

  // Next-state and datapath update; the result is registered on the last step
  // so hi/lo are valid during the FINISH cycle when done is high.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dvs_d   = dvs_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = mdu_op_t'(op);
          neg_d  = (a[WIDTH-1] ^ b[WIDTH-1]) & ~uns_s;
          rneg_d = a[WIDTH-1] & ~uns_s;
          cnt_d  = {CW{1'b0}};
          if (op && b_zero_s) begin
            state_d = FINISH;
            dz_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            dz_d    = 1'b0;
            dvs_d   = op ? b_mag_s : a_mag_s;
            acc_d   = {{WIDTH{1'b0}}, (op ? a_mag_s : b_mag_s)};
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = acc_step_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITERS - 1)) begin
          state_d = FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = res_hi_s;
          lo_d    = res_lo_s;
        end else begin
          state_d = RUN;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= MDU_MULT;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dvs_q   <= {WIDTH{1'b0}};
      acc_q   <= {W2{1'b0}};
      cnt_q   <= {CW{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dvs_q   <= dvs_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit; outputs sampled on the falling edge.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;
`ifdef MDU_UNSIGNED_EN
  logic        is_unsigned;
`endif

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32), .ITERS(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
`ifdef MDU_UNSIGNED_EN
    .is_unsigned (is_unsigned),
`endif
    .a           (a),
    .b           (b),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  function automatic exp_t model(input bit opv, input logic [31:0] av, input logic [31:0] bv,
                                 input bit uns);
    exp_t        e;
    longint      sa, sbv, q, r;
    logic [63:0] p;
    e.hi  = m_hi;
    e.lo  = m_lo;
    e.dz  = 1'b0;
    e.lat = 33;
    sa  = uns ? longint'({32'd0, av}) : longint'($signed(av));
    sbv = uns ? longint'({32'd0, bv}) : longint'($signed(bv));
    if (!opv) begin
      p    = 64'(sa * sbv);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (bv == 32'd0) begin
      e.dz  = 1'b1;
      e.lat = 1;
    end else begin
      q    = sa / sbv;
      r    = sa % sbv;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end
    return e;
  endfunction

  // Called at a falling edge while the unit is idle; returns at the falling edge after the start edge.
  task automatic issue(input bit opv, input logic [31:0] av, input logic [31:0] bv, input bit uns);
    exp_t e;
    e = model(opv, av, bv, uns);
    sb.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
    op = opv; a = av; b = bv; start = 1'b1;
`ifdef MDU_UNSIGNED_EN
    is_unsigned = uns;
`endif
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 1'($urandom);
  endtask

  task automatic collect(input string name, input int first);
    exp_t e;
    bit   got = 1'b0;
    int   lat = 0;
    int   busy_n = 0;
    for (int i = first; i <= 60 && !got; i++) begin
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        got = 1'b1;
        lat = i;
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_timeout: no done within 60 cycles", name);
    end
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s_scoreboard: empty queue", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin
      failures++; $display("FAIL %s_latency: got %0d want %0d", name, lat, e.lat);
    end
    checks++;
    if (busy_n !== ((e.lat == 1) ? 0 : (33 - first))) begin
      failures++; $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy_n,
                           (e.lat == 1) ? 0 : (33 - first));
    end
    checks++;
    if (hi !== e.hi) begin
      failures++; $display("FAIL %s_hi: got %h want %h", name, hi, e.hi);
    end
    checks++;
    if (lo !== e.lo) begin
      failures++; $display("FAIL %s_lo: got %h want %h", name, lo, e.lo);
    end
    checks++;
    if (div_zero !== e.dz) begin
      failures++; $display("FAIL %s_div_zero: got %b want %b", name, div_zero, e.dz);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL %s_done_pulse: done still %b after one cycle", name, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
`ifdef MDU_UNSIGNED_EN
    is_unsigned = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({hi, lo, busy, done, div_zero} !== 67'd0) begin
      failures++;
      $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b dz=%b want all zero",
               hi, lo, busy, done, div_zero);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    issue(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    collect("mult_7_m3", 1);
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, $urandom, $urandom, 1'b0);
      collect("mult_rand", 1);
    end
    issue(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    collect("mult_intmin_sq", 1);
  endtask

  task automatic test_div();
    issue(1'b1, 32'd100, 32'd7, 1'b0);
    collect("div_100_7", 1);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    collect("div_m7_2", 1);
    issue(1'b1, 32'd9, 32'hFFFF_FFFC, 1'b0);
    collect("div_9_m4", 1);
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, $urandom, 32'($urandom_range(1, 32'h0001_0000)) * ((i == 1) ? -32'sd1 : 32'sd1), 1'b0);
      collect("div_rand", 1);
    end
  endtask

  task automatic test_div_zero();
    issue(1'b1, 32'd100, 32'd7, 1'b0);
    collect("div_setup", 1);
    issue(1'b1, 32'd5, 32'd0, 1'b0);
    collect("div_by_zero", 1);
    issue(1'b0, 32'd3, 32'd4, 1'b0);
    collect("mult_clears_dz", 1);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    collect("div_intmin_m1", 1);
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 32'd12345, 32'hFFFF_0001, 1'b0);
    collect("b2b_first", 1);
    issue(1'b1, 32'hDEAD_BEEF, 32'd1000, 1'b0);
    // Start raised during the done cycle lands on FINISH and must be dropped.
    for (int i = 1; i <= 33; i++) begin
      if (done !== 1'b1) @(negedge clk);
    end
    begin
      exp_t e;
      bit   ok;
      e = sb.pop_front();
      checks++;
      ok = (done === 1'b1) && (lo === e.lo) && (hi === e.hi);
      if (!ok) begin
        failures++; $display("FAIL b2b_second: done=%b hi=%h lo=%h want hi=%h lo=%h",
                             done, hi, lo, e.hi, e.lo);
      end
    end
    start = 1'b1; op = 1'b0; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL start_in_finish: busy=%b want 0", busy);
    end
  endtask

  task automatic test_ignored_start();
    issue(1'b0, 32'd123456, 32'hFFFF_FCEB, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd77; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    collect("ignored_start", 6);
  endtask

  task automatic test_reset_midop();
    bit seen_done = 1'b0;
    bit seen_busy = 1'b0;
    issue(1'b1, 32'd1, 32'd0, 1'b0);
    collect("dz_before_reset", 1);
    issue(1'b0, 32'd99, 32'd98, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
      failures++; $display("FAIL reset_midop: busy=%b done=%b dz=%b hi=%h lo=%h want all zero",
                           busy, done, div_zero, hi, lo);
    end
    reset = 1'b0;
    sb.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
      if (busy === 1'b1) seen_busy = 1'b1;
    end
    checks++;
    if (seen_done || seen_busy) begin
      failures++; $display("FAIL reset_abort: done_seen=%b busy_seen=%b want 0", seen_done, seen_busy);
    end
  endtask

`ifdef MDU_UNSIGNED_EN
  task automatic test_unsigned();
    issue(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1);
    collect("multu", 1);
    issue(1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    collect("divu", 1);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    collect("divu_intmin", 1);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_ignored_start();
    test_reset_midop();
`ifdef MDU_UNSIGNED_EN
    test_unsigned();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
